// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port BRAM between the multicycle CPU (port 0, byte address) and the
//   program loader (port 1, word address). At most one access is issued per cycle. A read
//   tag pipe routes RAM read data back to the issuing port after RD_LAT cycles.
//
//   Build option: define LOADER_PRIO_EN for fixed priority (loader always wins a conflict).
//   The default build uses round-robin arbitration.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   p0_req/we/addr/wdata         CPU request (addr is a byte address)
//   p0_gnt/rvalid/rdata          CPU grant, read response
//   p1_req/we/addr/wdata         loader request (addr is a word address)
//   p1_gnt/rvalid/rdata          loader grant, read response
//   ram_en/we/addr/din, ram_dout RAM interface
module mem_port_arbiter #(
  parameter int unsigned AW     = 14,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic [AW-1:0] p0_word;
  logic          unused_p0_addr;
  assign p0_word        = p0_addr[AW+1:2];
  // Upper bits alias modulo 2**AW; byte-lane bits are meaningless for word access.
  assign unused_p0_addr = ^{p0_addr[31:AW+2], p0_addr[1:0]};

  logic gnt0, gnt1;

`ifdef LOADER_PRIO_EN
  // Fixed priority: no round-robin state exists in this build.
  assign gnt1 = ~rst & p1_req;
  assign gnt0 = ~rst & p0_req & ~p1_req;
`else
  // rr_last holds the port granted most recently; the other port wins a conflict.
  logic rr_last_q;
  assign gnt0 = ~rst & p0_req & (~p1_req | rr_last_q);
  assign gnt1 = ~rst & p1_req & (~p0_req | ~rr_last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else if (gnt0 | gnt1) begin
      rr_last_q <= gnt1;
    end
  end
`endif

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  // Address/data are held when idle so the RAM pins do not toggle needlessly.
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;

  always_comb begin
    ram_en   = gnt0 | gnt1;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_din  = din_q;
    if (gnt1) begin
      ram_we   = p1_we;
      ram_addr = p1_addr;
      ram_din  = p1_wdata;
    end else if (gnt0) begin
      ram_we   = p0_we;
      ram_addr = p0_word;
      ram_din  = p0_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      din_q  <= '0;
    end else if (ram_en) begin
      addr_q <= ram_addr;
      din_q  <= ram_din;
    end
  end

  // Response tag pipe: stage i holds the tag of the read issued i+1 cycles ago.
  logic [RD_LAT-1:0] tag_v_q;
  logic [RD_LAT-1:0] tag_p_q;
  logic              issue_rd;
  logic              tail_v, tail_p;

  assign issue_rd = ram_en & ~ram_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q <= '0;
      tag_p_q <= '0;
    end else begin
      tag_v_q[0] <= issue_rd;
      tag_p_q[0] <= gnt1;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_p_q[i] <= tag_p_q[i-1];
      end
    end
  end

  assign tail_v    = tag_v_q[RD_LAT-1];
  assign tail_p    = tag_p_q[RD_LAT-1];
  assign p0_rvalid = tail_v & ~tail_p;
  assign p1_rvalid = tail_v & tail_p;

  // rdata shows ram_dout in the rvalid cycle, then holds it until the next response.
  logic [DW-1:0] rdata0_q, rdata1_q;

  assign p0_rdata = p0_rvalid ? ram_dout : rdata0_q;
  assign p1_rdata = p1_rvalid ? ram_dout : rdata1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rdata0_q <= p0_rdata;
      rdata1_q <= p1_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned AW     = 14;
  localparam int unsigned DW     = 32;
  localparam int unsigned RD_LAT = 1;
`ifdef LOADER_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0]   p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_gnt, p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_gnt, p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Write-first RAM; unwritten words read as 0x1000_0000 + word address.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] rd1 = '0, rd2 = '0;
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] = ram_din;
    if (ram_en && !ram_we)
      rd1 <= mem.exists(ram_addr) ? mem[ram_addr] : (32'h1000_0000 | 32'(ram_addr));
    rd2 <= rd1;
  end
  assign ram_dout = (RD_LAT == 2) ? rd2 : rd1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic port, input logic [DW-1:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every rvalid pops one expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (p0_rvalid && p1_rvalid) begin
        total++; bad++;
        $display("FAIL rvalid_excl: both rvalid high at %0t", $time);
      end else if (p0_rvalid || p1_rvalid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: p0_rvalid=%b p1_rvalid=%b with nothing pending at %0t",
                   p0_rvalid, p1_rvalid, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_port", 32'(p1_rvalid), 32'(e.port));
          chk("rd_data", p1_rvalid ? p1_rdata : p0_rdata, e.data);
        end
      end
    end
  end

  // Check grant/RAM outputs in the middle of the cycle, then advance to just after posedge.
  task automatic tick(input logic eg0, input logic eg1, input logic [AW-1:0] eaddr);
    @(negedge clk);
    chk("p0_gnt", 32'(p0_gnt), 32'(eg0));
    chk("p1_gnt", 32'(p1_gnt), 32'(eg1));
    chk("ram_en", 32'(ram_en), 32'(eg0 | eg1));
    if (eg0 | eg1) chk("ram_addr", 32'(ram_addr), 32'(eaddr));
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'd0, p0_gnt, p1_gnt}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    chk({tag, "_ram_ctl"}, {30'd0, ram_en, ram_we}, 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_din"}, ram_din, 32'd0);
    chk({tag, "_p0_rdata"}, p0_rdata, 32'd0);
    chk({tag, "_p1_rdata"}, p1_rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w1;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. p0 read byte 0x94 -> word 0x25
    p0_req = 1; p0_we = 0; p0_addr = 32'h94;
    push(1'b0, 32'h1000_0025);
    tick(1, 0, 14'h25);
    p0_req = 0;
    tick(0, 0, '0);
    chk("t1_p1_rdata", p1_rdata, 32'd0);

    // 2. p1 writes word 7, p0 reads byte 0x1C next cycle
    p1_req = 1; p1_we = 1; p1_addr = 14'd7; p1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t2_ram_we", 32'(ram_we), 32'd1);
    chk("t2_ram_din", ram_din, 32'hDEAD_BEEF);
    tick(0, 1, 14'd7);
    p1_req = 0; p1_we = 0; p1_wdata = '0;
    p0_req = 1; p0_addr = 32'h1C;
    push(1'b0, 32'hDEAD_BEEF);
    tick(1, 0, 14'd7);
    p0_req = 0;
    tick(0, 0, '0);

    // 3. Both read continuously for 8 cycles; rr_last is now port 0, so p1 goes first
    p0_req = 1; p0_addr = 32'h40; p1_req = 1; p1_addr = 14'h20;
    for (int k = 0; k < 8; k++) begin
      w1 = PRIO ? 1'b1 : ((k % 2) == 0);
      if (w1) begin
        push(1'b1, 32'h1000_0020);
        tick(0, 1, 14'h20);
      end else begin
        push(1'b0, 32'h1000_0010);
        tick(1, 0, 14'h10);
      end
    end
    p0_req = 0; p1_req = 0;
    tick(0, 0, '0);

`ifdef LOADER_PRIO_EN
    // 4. Loader priority: p1 wins 4 cycles, p0 granted right after p1 drops
    p0_req = 1; p0_addr = 32'h40; p1_req = 1; p1_addr = 14'd5;
    for (int k = 0; k < 4; k++) begin
      push(1'b1, 32'h1000_0005);
      tick(0, 1, 14'd5);
    end
    p1_req = 0;
    push(1'b0, 32'h1000_0010);
    tick(1, 0, 14'h10);
    p0_req = 0;
    tick(0, 0, '0);
`endif

    // 6. Upper address bits ignored; then idle holds the address
    p0_req = 1; p0_addr = 32'hFFFF_0010;
    push(1'b0, 32'h1000_0004);
    tick(1, 0, 14'd4);
    p0_req = 0;
    @(negedge clk);
    chk("idle_en", {30'd0, ram_en, ram_we}, 32'd0);
    chk("idle_addr_hold", 32'(ram_addr), 32'd4);
    @(posedge clk); #1;
    tick(0, 0, '0);

    // 5. Reset one cycle after a p0 read grant: the read is dropped
    p0_req = 1; p0_addr = 32'h30;
    tick(1, 0, 14'hC);
    p0_req = 0;
    rst = 1;
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 0;
    p0_req = 1; p0_addr = 32'h8; p1_req = 1; p1_addr = 14'd3;
    if (PRIO) begin
      push(1'b1, 32'h1000_0003);
      tick(0, 1, 14'd3);
      p1_req = 0;
      push(1'b0, 32'h1000_0002);
      tick(1, 0, 14'd2);
      p0_req = 0;
    end else begin
      push(1'b0, 32'h1000_0002);
      tick(1, 0, 14'd2);
      p0_req = 0;
      push(1'b1, 32'h1000_0003);
      tick(0, 1, 14'd3);
      p1_req = 0;
    end

    // Drain outstanding responses with a bounded wait
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
